// File: rtl/spi_slave_regif_pkg.sv
// Shared definitions for the SPI register-file responder: FSM encoding,
// command-byte layout and the fixed fill/status constants.
package spi_regif_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam int               CMD_RW_BIT    = 7;
  localparam int               ADDR_W        = 7;
  localparam logic [7:0]       OOR_READ_DATA = 8'hFF;
  localparam logic [7:0]       CMD_MISO_FILL = 8'h00;
  localparam logic [ADDR_W-1:0] STATUS_ADDR  = 7'd127;

  // Sticky status layout (only meaningful with the irq option built in).
  localparam int STAT_WR_BIT  = 0;
  localparam int STAT_ERR_BIT = 1;

endpackage

// File: rtl/spi_slave_regif_if.sv
// SPI pin bundle. The master modport drives the bus lines, the slave
// modport drives MISO and its output enable.
interface spi_slave_regif_if;

  logic sck;
  logic mosi;
  logic ss_n;
  logic miso;
  logic miso_oe;

  modport master (output sck, output mosi, output ss_n, input miso, input miso_oe);
  modport slave  (input sck, input mosi, input ss_n, output miso, output miso_oe);

endinterface

// File: rtl/spi_slave_sync.sv
// Brings the asynchronous SPI pins into the clk domain and turns SCK
// transitions into single-clk sample/shift strobes for the selected mode.
// Strobes are suppressed while the synchronised select is high.
module spi_slave_sync #(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic mosi,
  input  logic ss_n,
  output logic mosi_s,
  output logic ss_fall,
  output logic ss_rise,
  output logic sample_stb,
  output logic shift_stb
);

  logic [1:0] sck_m;
  logic [1:0] mosi_m;
  logic [1:0] ss_m;
  logic       sck_d;
  logic       ss_d;
  logic       sck_rise;
  logic       sck_fall;
  logic       lead_edge;
  logic       trail_edge;

  // Two-flop synchronisers plus one extra stage per edge-detected line.
  // Select flops reset low so a select that is already high after reset
  // only produces a harmless rise, never a false frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_m  <= {2{CPOL}};
      sck_d  <= CPOL;
      mosi_m <= '0;
      ss_m   <= '0;
      ss_d   <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbour, as the hardware does.
      sck_m  <= {sck_m[0], sck};
      sck_d  <= sck_m[1];
      mosi_m <= {mosi_m[0], mosi};
      ss_m   <= {ss_m[0], ss_n};
      ss_d   <= ss_m[1];
    end
  end

  assign sck_rise   = sck_m[1] & ~sck_d;
  assign sck_fall   = ~sck_m[1] & sck_d;
  assign lead_edge  = CPOL ? sck_fall : sck_rise;
  assign trail_edge = CPOL ? sck_rise : sck_fall;

  assign mosi_s     = mosi_m[1];
  assign ss_fall    = ~ss_m[1] & ss_d;
  assign ss_rise    = ss_m[1] & ~ss_d;
  assign sample_stb = ~ss_m[1] & (CPHA ? trail_edge : lead_edge);
  assign shift_stb  = ~ss_m[1] & (CPHA ? lead_edge : trail_edge);

endmodule

// File: rtl/spi_slave_regif.sv
// SPI responder exposing an 8-bit register file. Frames are a command
// byte {rw, addr[6:0]} followed by data bytes; the address increments
// after every data byte and wraps 127 -> 0.
// Build option SPI_SLAVE_REGIF_IRQ_EN adds an irq output and a
// clear-on-read sticky status register at address 127.
module spi_slave_regif
  import spi_regif_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter bit CPOL     = 1'b0,
  parameter bit CPHA     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_slave_regif_if.slave      spi,
  output logic [NUM_REGS*8-1:0] regs_q,
  output logic                  wr_pulse,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic                  err
`ifdef SPI_SLAVE_REGIF_IRQ_EN
  ,
  output logic                  irq
`endif
);

  state_e            state;
  logic [2:0]        bit_cnt;
  logic [7:0]        rx_sr;
  logic [7:0]        tx_sr;
  logic [7:0]        rd_byte;     // prefetched byte for the next MISO load
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic              byte_done;   // high the clk after the 8th sample
  logic              load_pend;   // CPHA=0: next shift edge loads rd_byte
  logic [7:0]        regs [NUM_REGS];

  logic              mosi_s;
  logic              ss_fall;
  logic              ss_rise;
  logic              sample_stb;
  logic              shift_stb;

  logic              tx_load;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_rw;

`ifdef SPI_SLAVE_REGIF_IRQ_EN
  logic [1:0]        status;
  logic              rd_is_stat;
  logic              stat_clr;
  logic              stat_load;
`endif

  spi_slave_sync #(.CPOL(CPOL), .CPHA(CPHA)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .sck        (spi.sck),
    .mosi       (spi.mosi),
    .ss_n       (spi.ss_n),
    .mosi_s     (mosi_s),
    .ss_fall    (ss_fall),
    .ss_rise    (ss_rise),
    .sample_stb (sample_stb),
    .shift_stb  (shift_stb)
  );

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  function automatic logic [7:0] reg_at(input logic [ADDR_W-1:0] a);
    logic [7:0] v;
    v = OOR_READ_DATA;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (a == ADDR_W'(i)) v = regs[i];
    end
    return v;
  endfunction

  // Address/direction of the byte to prefetch when a byte completes, and
  // whether this shift edge reloads tx_sr instead of shifting it.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    fetch_addr = addr + ADDR_W'(1);
    fetch_rw   = rw;
    if (state == CMD) begin
      fetch_addr = rx_sr[ADDR_W-1:0];
      fetch_rw   = rx_sr[CMD_RW_BIT];
    end
    tx_load = shift_stb && (CPHA ? (bit_cnt == 3'd0) : load_pend);
  end

  // Frame FSM, shift registers, register file writes and read prefetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      rd_byte   <= '0;
      rw        <= 1'b0;
      addr      <= '0;
      byte_done <= 1'b0;
      load_pend <= 1'b0;
      spi.miso_oe <= 1'b0;
      wr_pulse  <= 1'b0;
      wr_addr   <= '0;
      err       <= 1'b0;
`ifdef SPI_SLAVE_REGIF_IRQ_EN
      rd_is_stat <= 1'b0;
`endif
      // NOTE: the register file is architecturally visible and must read
      // zero after reset, so each entry is reset explicitly.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_pulse  <= 1'b0;
      err       <= 1'b0;
      byte_done <= 1'b0;
      if (ss_rise) begin
        // Deselect: any partial byte is dropped and MISO returns to 0.
        state       <= IDLE;
        bit_cnt     <= '0;
        tx_sr       <= '0;
        load_pend   <= 1'b0;
        spi.miso_oe <= 1'b0;
      end else if (state == IDLE) begin
        if (ss_fall) begin
          state       <= CMD;
          bit_cnt     <= '0;
          tx_sr       <= CMD_MISO_FILL;
          spi.miso_oe <= 1'b1;
        end
      end else begin
        if (sample_stb) begin
          rx_sr   <= {rx_sr[6:0], mosi_s};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_done <= 1'b1;
            load_pend <= !CPHA;
          end
        end

        if (tx_load) begin
          tx_sr     <= (state == CMD) ? CMD_MISO_FILL : rd_byte;
          load_pend <= 1'b0;
        end else if (shift_stb) begin
          tx_sr <= {tx_sr[6:0], 1'b0};
        end

        if (byte_done) begin
          if (state == CMD) begin
            state <= DATA;
            rw    <= rx_sr[CMD_RW_BIT];
            addr  <= rx_sr[ADDR_W-1:0];
          end else begin
            addr <= addr + ADDR_W'(1);
            if (!rw) begin
`ifdef SPI_SLAVE_REGIF_IRQ_EN
              if (addr == STATUS_ADDR) begin
                // Status is read-only; writes to it are silently ignored.
              end else
`endif
              if (in_range(addr)) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                  if (addr == ADDR_W'(i)) regs[i] <= rx_sr;
                end
                wr_pulse <= 1'b1;
                wr_addr  <= addr;
              end else begin
                err <= 1'b1;
              end
            end
          end

          // Prefetch the next MISO byte; a write above lands in regs
          // before any later fetch of the same address.
          rd_byte <= reg_at(fetch_addr);
`ifdef SPI_SLAVE_REGIF_IRQ_EN
          rd_is_stat <= (fetch_addr == STATUS_ADDR);
          if (fetch_addr == STATUS_ADDR) begin
            rd_byte <= {6'b0, status};
          end else if (fetch_rw && !in_range(fetch_addr)) begin
            err <= 1'b1;
          end
`else
          if (fetch_rw && !in_range(fetch_addr)) err <= 1'b1;
`endif
        end
      end
    end
  end

`ifdef SPI_SLAVE_REGIF_IRQ_EN
  assign stat_load = tx_load && (state == DATA) && rd_is_stat;

  // Sticky status: set by write/error pulses, cleared the clk after a
  // status byte has been loaded for shifting out.
  always_ff @(posedge clk) begin
    if (rst) begin
      status   <= '0;
      stat_clr <= 1'b0;
    end else begin
      stat_clr <= stat_load;
      status   <= (stat_clr ? 2'b00 : status) | {err, wr_pulse};
    end
  end

  assign irq = |status;
`endif

  assign spi.miso = tx_sr[7];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_q[g*8 +: 8] = regs[g];
  end

endmodule
